// File: rtl/ocp_req_gen.sv
// -----------------------------------------------------------------------------
// ocp_req_gen
//
// Converts PCIe memory request TLPs arriving on a 64-bit AXI-Stream RX
// interface into single-DW OCP write commands and OCP read-burst commands.
// MRd3/MRd4 produce one RD command carrying the TLP length as burst length.
// MWr3/MWr4 produce one WR command per payload DW, fed through a two-DW
// holding buffer. Any other TLP type is flagged and drained; a TLP that ends
// before its header or payload is complete is flagged as malformed.
//
// Ports
//   clk              rising-edge clock for all logic
//   reset            asynchronous, active-high reset
//   rx_tdata         TLP beat, DW0 = [31:0], DW1 = [63:32]
//   rx_tvalid        beat valid
//   rx_tkeep         byte keep, 8'h0F (one DW) or 8'hFF (two DWs)
//   rx_tlast         last beat of the TLP
//   rx_tready        beat accepted when rx_tvalid && rx_tready
//   ocp_mcmd         000 IDLE, 001 WR, 010 RD
//   ocp_maddr        byte address of the current command
//   ocp_mdata        write DW
//   ocp_mbyteen      byte enables
//   ocp_mburstlength read burst length in DWs (1..1024)
//   ocp_scmdaccept   slave accepts the current command
//   unsupported_req  one-cycle pulse on a non-MRd/MWr TLP
//   malformed_tlp    one-cycle pulse on an early rx_tlast
// -----------------------------------------------------------------------------
module ocp_req_gen #(
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] rx_tdata,
   input  logic                  rx_tvalid,
   input  logic [KEEP_WIDTH-1:0] rx_tkeep,
   input  logic                  rx_tlast,
   output logic                  rx_tready,
   output logic [2:0]            ocp_mcmd,
   output logic [63:0]           ocp_maddr,
   output logic [31:0]           ocp_mdata,
   output logic [3:0]            ocp_mbyteen,
   output logic [10:0]           ocp_mburstlength,
   input  logic                  ocp_scmdaccept,
   output logic                  unsupported_req,
   output logic                  malformed_tlp
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HDR2    = 3'd1,
      S_WR_DATA = 3'd2,
      S_RD_REQ  = 3'd3,
      S_DRAIN   = 3'd4
   } state_t;

   localparam logic [2:0] CMD_IDLE = 3'b000;
   localparam logic [2:0] CMD_WR   = 3'b001;
   localparam logic [2:0] CMD_RD   = 3'b010;

   // ---------------------------------------------------------------------------
   // State and captured header
   // ---------------------------------------------------------------------------
   state_t      state;
   logic [1:0]  hdr_fmt;       // [1] = write, [0] = 4DW header
   logic [4:0]  hdr_type;
   logic [10:0] hdr_len;       // 1..1024 DWs
   logic [3:0]  first_be;
   logic [3:0]  last_be;
   logic [63:0] base_addr;
   logic [10:0] idx;           // payload DWs already accepted by the slave
   logic [10:0] fetched;       // payload DWs already pulled from the stream
   logic [31:0] buf0;          // oldest buffered DW
   logic [31:0] buf1;
   logic [1:0]  buf_cnt;
   logic        tlast_seen;    // the TLP's final beat has been consumed

   // Next-state values
   state_t      nxt_state;
   logic [1:0]  nxt_fmt;
   logic [4:0]  nxt_type;
   logic [10:0] nxt_len;
   logic [3:0]  nxt_first_be;
   logic [3:0]  nxt_last_be;
   logic [63:0] nxt_base_addr;
   logic [10:0] nxt_idx;
   logic [10:0] nxt_fetched;
   logic [31:0] nxt_buf0;
   logic [31:0] nxt_buf1;
   logic [1:0]  nxt_buf_cnt;
   logic        nxt_tlast_seen;

   // Next values of the registered outputs
   logic        nxt_ready;
   logic [2:0]  nxt_mcmd;
   logic [63:0] nxt_maddr;
   logic [31:0] nxt_mdata;
   logic [3:0]  nxt_mbyteen;
   logic [10:0] nxt_mburstlength;
   logic        nxt_unsupported;
   logic        nxt_malformed;

   // Helpers
   logic        beat;
   logic        pop;
   logic        two_dw;
   logic [10:0] remaining;
   logic [10:0] load_cnt;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      nxt_state      = state;
      nxt_fmt        = hdr_fmt;
      nxt_type       = hdr_type;
      nxt_len        = hdr_len;
      nxt_first_be   = first_be;
      nxt_last_be    = last_be;
      nxt_base_addr  = base_addr;
      nxt_idx        = idx;
      nxt_fetched    = fetched;
      nxt_buf0       = buf0;
      nxt_buf1       = buf1;
      nxt_buf_cnt    = buf_cnt;
      nxt_tlast_seen = tlast_seen;
      nxt_unsupported = 1'b0;
      nxt_malformed   = 1'b0;

      beat      = rx_tvalid && rx_tready;
      // A WR command is on the bus exactly when WR_DATA holds a buffered DW.
      pop       = (state == S_WR_DATA) && (buf_cnt != 2'd0) && ocp_scmdaccept;
      remaining = hdr_len - fetched;
      // A full-keep beat carries two DWs unless only one is still owed.
      two_dw    = (rx_tkeep != 8'h0F) && (remaining > 11'd1);
      load_cnt  = two_dw ? 11'd2 : 11'd1;

      unique case (state)
         S_IDLE: begin
            if (beat) begin
               nxt_fmt        = rx_tdata[30:29];
               nxt_type       = rx_tdata[28:24];
               nxt_len        = (rx_tdata[9:0] == 10'd0) ? 11'd1024 : {1'b0, rx_tdata[9:0]};
               nxt_first_be   = rx_tdata[35:32];
               nxt_last_be    = rx_tdata[39:36];
               nxt_idx        = '0;
               nxt_fetched    = '0;
               nxt_buf_cnt    = '0;
               nxt_tlast_seen = 1'b0;
               if (rx_tlast) nxt_malformed = 1'b1;
               else          nxt_state     = S_HDR2;
            end
         end

         S_HDR2: begin
            if (beat) begin
               nxt_base_addr = hdr_fmt[0] ? {rx_tdata[31:0], rx_tdata[63:34], 2'b00}
                                          : {32'h0, rx_tdata[31:2], 2'b00};
               if (hdr_type != 5'b00000) begin
                  nxt_unsupported = 1'b1;
                  nxt_state       = rx_tlast ? S_IDLE : S_DRAIN;
               end else if (!hdr_fmt[1]) begin
                  nxt_state = S_RD_REQ;
               end else if (!hdr_fmt[0]) begin
                  // MWr3: the upper DW of the header beat is payload DW 0.
                  nxt_buf0    = rx_tdata[63:32];
                  nxt_buf_cnt = 2'd1;
                  nxt_fetched = 11'd1;
                  nxt_state   = S_WR_DATA;
                  if (rx_tlast) begin
                     nxt_tlast_seen = 1'b1;
                     if (hdr_len != 11'd1) nxt_malformed = 1'b1;
                  end
               end else if (rx_tlast) begin
                  // MWr4 ending with its header: nothing to write.
                  nxt_malformed = 1'b1;
                  nxt_state     = S_IDLE;
               end else begin
                  nxt_state = S_WR_DATA;
               end
            end
         end

         S_RD_REQ: begin
            if (ocp_scmdaccept) nxt_state = S_IDLE;
         end

         S_WR_DATA: begin
            // rx_tready is only high with an empty buffer, so a pop and a
            // refill never coincide.
            if (pop) begin
               nxt_buf0    = buf1;
               nxt_buf_cnt = buf_cnt - 2'd1;
               nxt_idx     = idx + 11'd1;
               if ((buf_cnt == 2'd1) && (tlast_seen || (nxt_idx == hdr_len)))
                  nxt_state = tlast_seen ? S_IDLE : S_DRAIN;
            end else if (beat) begin
               nxt_buf0    = rx_tdata[31:0];
               nxt_buf1    = rx_tdata[63:32];
               nxt_buf_cnt = two_dw ? 2'd2 : 2'd1;
               nxt_fetched = fetched + load_cnt;
               if (rx_tlast) begin
                  nxt_tlast_seen = 1'b1;
                  // Final beat left DWs unfetched: flag it, still write what
                  // arrived, then return to IDLE.
                  if (remaining > load_cnt) nxt_malformed = 1'b1;
               end
            end
         end

         S_DRAIN: begin
            if (beat && rx_tlast) nxt_state = S_IDLE;
         end

         default: nxt_state = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output decode from the next state, so every output is a register
   // ---------------------------------------------------------------------------
   always_comb begin
      nxt_mcmd         = CMD_IDLE;
      nxt_maddr        = '0;
      nxt_mdata        = '0;
      nxt_mbyteen      = '0;
      nxt_mburstlength = '0;

      unique case (nxt_state)
         S_RD_REQ: nxt_ready = 1'b0;
         S_WR_DATA: nxt_ready = (nxt_buf_cnt == 2'd0) && !nxt_tlast_seen &&
                                (nxt_fetched != nxt_len);
         default:  nxt_ready = 1'b1;
      endcase

      if (nxt_state == S_RD_REQ) begin
         nxt_mcmd         = CMD_RD;
         nxt_maddr        = nxt_base_addr;
         nxt_mburstlength = nxt_len;
         nxt_mbyteen      = nxt_first_be;
      end else if ((nxt_state == S_WR_DATA) && (nxt_buf_cnt != 2'd0)) begin
         nxt_mcmd         = CMD_WR;
         nxt_mdata        = nxt_buf0;
         // 64-bit add wraps naturally modulo 2^64.
         nxt_maddr        = nxt_base_addr + {51'h0, nxt_idx, 2'b00};
         nxt_mburstlength = 11'd1;
         if (nxt_idx == 11'd0)                  nxt_mbyteen = nxt_first_be;
         else if (nxt_idx == (nxt_len - 11'd1)) nxt_mbyteen = nxt_last_be;
         else                                   nxt_mbyteen = 4'hF;
      end
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the two-entry holding buffer is plain flops, so it is
         // cleared with everything else; a larger RAM-style buffer would not
         // be reset and would rely on buf_cnt instead.
         state            <= S_IDLE;
         hdr_fmt          <= '0;
         hdr_type         <= '0;
         hdr_len          <= '0;
         first_be         <= '0;
         last_be          <= '0;
         base_addr        <= '0;
         idx              <= '0;
         fetched          <= '0;
         buf0             <= '0;
         buf1             <= '0;
         buf_cnt          <= '0;
         tlast_seen       <= 1'b0;
         rx_tready        <= 1'b0;
         ocp_mcmd         <= CMD_IDLE;
         ocp_maddr        <= '0;
         ocp_mdata        <= '0;
         ocp_mbyteen      <= '0;
         ocp_mburstlength <= '0;
         unsupported_req  <= 1'b0;
         malformed_tlp    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples
         // the values from before this edge, independent of statement order.
         state            <= nxt_state;
         hdr_fmt          <= nxt_fmt;
         hdr_type         <= nxt_type;
         hdr_len          <= nxt_len;
         first_be         <= nxt_first_be;
         last_be          <= nxt_last_be;
         base_addr        <= nxt_base_addr;
         idx              <= nxt_idx;
         fetched          <= nxt_fetched;
         buf0             <= nxt_buf0;
         buf1             <= nxt_buf1;
         buf_cnt          <= nxt_buf_cnt;
         tlast_seen       <= nxt_tlast_seen;
         rx_tready        <= nxt_ready;
         ocp_mcmd         <= nxt_mcmd;
         ocp_maddr        <= nxt_maddr;
         ocp_mdata        <= nxt_mdata;
         ocp_mbyteen      <= nxt_mbyteen;
         ocp_mburstlength <= nxt_mburstlength;
         unsupported_req  <= nxt_unsupported;
         malformed_tlp    <= nxt_malformed;
      end
   end

endmodule

// File: tb/tb_ocp_req_gen.sv
// -----------------------------------------------------------------------------
// tb_ocp_req_gen
//
// Directed bench for ocp_req_gen. Beats are driven just after a rising edge,
// DUT outputs are sampled on the falling edge. A monitor logs every accepted
// OCP command and counts status pulses; tests compare against hand-computed
// values.
// -----------------------------------------------------------------------------
module tb_ocp_req_gen;

   logic        clk;
   logic        reset;
   logic [63:0] rx_tdata;
   logic        rx_tvalid;
   logic [7:0]  rx_tkeep;
   logic        rx_tlast;
   logic        rx_tready;
   logic [2:0]  ocp_mcmd;
   logic [63:0] ocp_maddr;
   logic [31:0] ocp_mdata;
   logic [3:0]  ocp_mbyteen;
   logic [10:0] ocp_mburstlength;
   logic        ocp_scmdaccept;
   logic        unsupported_req;
   logic        malformed_tlp;

   ocp_req_gen #(.DATA_WIDTH(64), .KEEP_WIDTH(8)) dut (
      .clk              (clk),
      .reset            (reset),
      .rx_tdata         (rx_tdata),
      .rx_tvalid        (rx_tvalid),
      .rx_tkeep         (rx_tkeep),
      .rx_tlast         (rx_tlast),
      .rx_tready        (rx_tready),
      .ocp_mcmd         (ocp_mcmd),
      .ocp_maddr        (ocp_maddr),
      .ocp_mdata        (ocp_mdata),
      .ocp_mbyteen      (ocp_mbyteen),
      .ocp_mburstlength (ocp_mburstlength),
      .ocp_scmdaccept   (ocp_scmdaccept),
      .unsupported_req  (unsupported_req),
      .malformed_tlp    (malformed_tlp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;
   int n_unsup = 0;
   int n_malf  = 0;
   int n_viol  = 0;

   logic [2:0]  q_cmd[$];
   logic [63:0] q_addr[$];
   logic [31:0] q_data[$];
   logic [3:0]  q_be[$];

   // Command log and pulse counters, sampled away from the active edge.
   always @(negedge clk) begin
      if (ocp_mcmd != 3'b000 && ocp_scmdaccept) begin
         q_cmd.push_back(ocp_mcmd);
         q_addr.push_back(ocp_maddr);
         q_data.push_back(ocp_mdata);
         q_be.push_back(ocp_mbyteen);
      end
      if (unsupported_req) n_unsup++;
      if (malformed_tlp)   n_malf++;
      if (ocp_mcmd == 3'b001 && rx_tready) n_viol++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      q_cmd.delete();
      q_addr.delete();
      q_data.delete();
      q_be.delete();
   endtask

   // Call just after a rising edge; returns just after the accepting edge.
   task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
      int n;
      n = 0;
      rx_tdata  = d;
      rx_tkeep  = k;
      rx_tlast  = l;
      rx_tvalid = 1'b1;
      @(negedge clk);
      while (!rx_tready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("beat_ready", 64'(rx_tready), 64'(1'b1));
      @(posedge clk);
      #1;
      rx_tvalid = 1'b0;
      rx_tlast  = 1'b0;
      rx_tdata  = '0;
      rx_tkeep  = 8'hFF;
   endtask

   task automatic wait_cmds(input string tag, input int n);
      for (int i = 0; i < 200 && q_cmd.size() < n; i++) @(posedge clk);
      #1;
      check(tag, 64'(q_cmd.size()), 64'(n));
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_wr(input string tag, input int i, input logic [63:0] a,
                           input logic [31:0] d, input logic [3:0] be);
      check({tag, "_cmd"},  64'(q_cmd[i]),  64'(3'b001));
      check({tag, "_addr"}, q_addr[i],      a);
      check({tag, "_data"}, 64'(q_data[i]), 64'(d));
      check({tag, "_be"},   64'(q_be[i]),   64'(be));
   endtask

   int base;

   initial begin
      reset          = 1'b1;
      rx_tdata       = '0;
      rx_tvalid      = 1'b0;
      rx_tkeep       = 8'hFF;
      rx_tlast       = 1'b0;
      ocp_scmdaccept = 1'b0;

      // ---- reset state ----
      #3;
      check("rst_ready", 64'(rx_tready), 64'(1'b0));
      check("rst_mcmd",  64'(ocp_mcmd), 64'(3'b000));
      check("rst_maddr", ocp_maddr, 64'h0);
      check("rst_mdata", 64'(ocp_mdata), 64'h0);
      check("rst_be",    64'(ocp_mbyteen), 64'h0);
      check("rst_bl",    64'(ocp_mburstlength), 64'h0);
      check("rst_unsup", 64'(unsupported_req), 64'h0);
      check("rst_malf",  64'(malformed_tlp), 64'h0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
      check("ready_after_rst", 64'(rx_tready), 64'(1'b1));

      // ---- MRd3 len 4 @0x1000, held three cycles without accept ----
      send_beat({32'h0000_000F, 32'h0000_0004}, 8'hFF, 1'b0);
      send_beat({32'h0000_0000, 32'h0000_1000}, 8'h0F, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rd_mcmd",  64'(ocp_mcmd), 64'(3'b010));
         check("rd_maddr", ocp_maddr, 64'h1000);
         check("rd_bl",    64'(ocp_mburstlength), 64'd4);
         check("rd_be",    64'(ocp_mbyteen), 64'hF);
         check("rd_ready", 64'(rx_tready), 64'(1'b0));
      end
      @(posedge clk);
      #1 ocp_scmdaccept = 1'b1;
      @(posedge clk);
      #1;
      check("rd_done_mcmd",  64'(ocp_mcmd), 64'(3'b000));
      check("rd_done_maddr", ocp_maddr, 64'h0);
      check("rd_done_bl",    64'(ocp_mburstlength), 64'h0);
      check("rd_done_be",    64'(ocp_mbyteen), 64'h0);
      check("rd_done_ready", 64'(rx_tready), 64'(1'b1));
      check("rd_count",      64'(q_cmd.size()), 64'd1);

      // ---- MWr3 len 3 @0x2000, firstBE 3 lastBE C ----
      clear_log();
      send_beat({32'h0000_00C3, 32'h4000_0003}, 8'hFF, 1'b0);
      send_beat({32'hA0A0_0001, 32'h0000_2000}, 8'hFF, 1'b0);
      @(negedge clk);
      check("wr3_ready_busy", 64'(rx_tready), 64'(1'b0));
      send_beat({32'hA0A0_0003, 32'hA0A0_0002}, 8'hFF, 1'b1);
      wait_cmds("wr3_count", 3);
      check_wr("wr3_0", 0, 64'h2000, 32'hA0A0_0001, 4'h3);
      check_wr("wr3_1", 1, 64'h2004, 32'hA0A0_0002, 4'hF);
      check_wr("wr3_2", 2, 64'h2008, 32'hA0A0_0003, 4'hC);
      idle_cycles(2);

      // ---- MWr4 len 1 @0x1_0000_0010, last beat keep 0F ----
      clear_log();
      base = n_malf;
      send_beat({32'h0000_000F, 32'h6000_0001}, 8'hFF, 1'b0);
      send_beat({32'h0000_0010, 32'h0000_0001}, 8'hFF, 1'b0);
      send_beat({32'h0000_0000, 32'hDEAD_BEEF}, 8'h0F, 1'b1);
      wait_cmds("wr4_count", 1);
      check_wr("wr4_0", 0, 64'h1_0000_0010, 32'hDEAD_BEEF, 4'hF);
      idle_cycles(2);
      check("wr4_no_malf", 64'(n_malf), 64'(base));
      check("wr4_ready",   64'(rx_tready), 64'(1'b1));

      // ---- CfgRd: unsupported, drained ----
      clear_log();
      base = n_unsup;
      send_beat({32'h0000_0000, 32'h0400_0001}, 8'hFF, 1'b0);
      send_beat({32'h0000_0000, 32'h0000_5000}, 8'hFF, 1'b0);
      send_beat({32'h1234_5678, 32'h0000_0000}, 8'hFF, 1'b1);
      idle_cycles(3);
      check("cfg_unsup", 64'(n_unsup), 64'(base + 1));
      check("cfg_no_cmd", 64'(q_cmd.size()), 64'd0);
      check("cfg_ready", 64'(rx_tready), 64'(1'b1));

      // ---- MWr4 len 4 with tlast on the first data beat ----
      clear_log();
      base = n_malf;
      send_beat({32'h0000_00FF, 32'h6000_0004}, 8'hFF, 1'b0);
      send_beat({32'h0000_3000, 32'h0000_0000}, 8'hFF, 1'b0);
      send_beat({32'hE000_0001, 32'hE000_0000}, 8'hFF, 1'b1);
      wait_cmds("early_count", 2);
      idle_cycles(3);
      check_wr("early_0", 0, 64'h3000, 32'hE000_0000, 4'hF);
      check_wr("early_1", 1, 64'h3004, 32'hE000_0001, 4'hF);
      check("early_malf", 64'(n_malf), 64'(base + 1));
      check("early_total", 64'(q_cmd.size()), 64'd2);
      check("early_ready", 64'(rx_tready), 64'(1'b1));

      // ---- tlast on the very first beat ----
      clear_log();
      base = n_malf;
      send_beat({32'h0000_000F, 32'h0000_0001}, 8'hFF, 1'b1);
      idle_cycles(2);
      check("short_malf",  64'(n_malf), 64'(base + 1));
      check("short_ready", 64'(rx_tready), 64'(1'b1));
      check("short_no_cmd", 64'(q_cmd.size()), 64'd0);

      // ---- MRd4 len field 0 = 1024 DWs, top-of-memory address ----
      clear_log();
      send_beat({32'h0000_000F, 32'h2000_0000}, 8'hFF, 1'b0);
      send_beat({32'hFFFF_FFFF, 32'hFFFF_FFFF}, 8'hFF, 1'b1);
      @(negedge clk);
      check("rd4_mcmd",  64'(ocp_mcmd), 64'(3'b010));
      check("rd4_maddr", ocp_maddr, 64'hFFFF_FFFF_FFFF_FFFC);
      check("rd4_bl",    64'(ocp_mburstlength), 64'd1024);
      wait_cmds("rd4_count", 1);
      idle_cycles(2);

      // ---- MWr4 len 2 wrapping past 2^64 ----
      clear_log();
      send_beat({32'h0000_0031, 32'h6000_0002}, 8'hFF, 1'b0);
      send_beat({32'hFFFF_FFFC, 32'hFFFF_FFFF}, 8'hFF, 1'b0);
      send_beat({32'hC000_0002, 32'hC000_0001}, 8'hFF, 1'b1);
      wait_cmds("wrap_count", 2);
      check_wr("wrap_0", 0, 64'hFFFF_FFFF_FFFF_FFFC, 32'hC000_0001, 4'h1);
      check_wr("wrap_1", 1, 64'h0, 32'hC000_0002, 4'h3);
      idle_cycles(2);

      // ---- reset during the second WR of an MWr3, then MRd3 ----
      clear_log();
      send_beat({32'h0000_00C3, 32'h4000_0003}, 8'hFF, 1'b0);
      send_beat({32'hA0A0_0001, 32'h0000_2000}, 8'hFF, 1'b0);
      send_beat({32'hA0A0_0003, 32'hA0A0_0002}, 8'hFF, 1'b1);
      check("mid_mcmd",  64'(ocp_mcmd), 64'(3'b001));
      check("mid_maddr", ocp_maddr, 64'h2004);
      reset = 1'b1;
      #1;
      check("mid_rst_mcmd",  64'(ocp_mcmd), 64'(3'b000));
      check("mid_rst_maddr", ocp_maddr, 64'h0);
      check("mid_rst_mdata", 64'(ocp_mdata), 64'h0);
      check("mid_rst_ready", 64'(rx_tready), 64'(1'b0));
      idle_cycles(2);
      reset = 1'b0;
      idle_cycles(1);
      check("post_rst_ready", 64'(rx_tready), 64'(1'b1));
      send_beat({32'h0000_0005, 32'h0000_0002}, 8'hFF, 1'b0);
      send_beat({32'h0000_0000, 32'h0000_4000}, 8'h0F, 1'b1);
      @(negedge clk);
      check("post_rd_mcmd",  64'(ocp_mcmd), 64'(3'b010));
      check("post_rd_maddr", ocp_maddr, 64'h4000);
      check("post_rd_bl",    64'(ocp_mburstlength), 64'd2);
      check("post_rd_be",    64'(ocp_mbyteen), 64'h5);
      wait_cmds("post_count", 2);
      check("post_first_wr", 64'(q_cmd[0]), 64'(3'b001));
      check("post_then_rd",  64'(q_cmd[1]), 64'(3'b010));
      idle_cycles(2);

      check("wr_ready_overlap", 64'(n_viol), 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
